// File: rtl/midi_ctrl.sv
// Four-button MIDI controller: debounces buttons and sends Note On/Off messages
// as 31250-baud 8N1 serial frames on midi_tx.
module midi_ctrl #(
    parameter int unsigned BAUD_CNT_HALF = 800,
    parameter int unsigned DEBOUNCE_CNT  = BAUD_CNT_HALF * 64
) (
    input  logic rst,
    input  logic clk,
    input  logic btn1,
    input  logic btn2,
    input  logic btn3,
    input  logic btn4,
    output logic led1,
    output logic led2,
    output logic midi_tx
);

    localparam int unsigned BAUD_TOP = 2 * BAUD_CNT_HALF - 1;
    localparam int unsigned BW       = (BAUD_TOP > 0) ? $clog2(BAUD_TOP + 1) : 1;
    localparam int unsigned DW       = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [3:0]  BIT_STOP = 4'd9;
    localparam logic [1:0]  BYTE_END = 2'd2;

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [3:0]    btn_raw;
    logic [3:0]    sync1_q;
    logic [3:0]    sync2_q;
    logic [3:0]    deb_q;
    logic [DW-1:0] deb_cnt_q [4];

    assign btn_raw = {btn4, btn3, btn2, btn1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DW'(DEBOUNCE_CNT - 1)) begin
                    deb_q[i]     <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Event arbitration: lowest-index button whose state is unreported
    // ------------------------------------------------------------------
    logic [3:0] rep_q;
    logic       evt_valid;
    logic [1:0] evt_idx;
    logic       evt_level;

    always_comb begin
        evt_valid = 1'b0;
        evt_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (deb_q[i] != rep_q[i]) begin
                evt_valid = 1'b1;
                evt_idx   = 2'(i);
            end
        end
    end

    assign evt_level = deb_q[evt_idx];

    // ------------------------------------------------------------------
    // Serial transmitter
    // ------------------------------------------------------------------
    state_e        state_q;
    logic [BW-1:0] baud_q;
    logic [3:0]    bit_q;
    logic [1:0]    byte_q;
    logic [23:0]   msg_q;
    logic [7:0]    cur_byte;
    logic          next_bit;

    always_comb begin
        cur_byte = msg_q[7:0];
        unique case (byte_q)
            2'd0:    cur_byte = msg_q[23:16];
            2'd1:    cur_byte = msg_q[15:8];
            default: cur_byte = msg_q[7:0];
        endcase
    end

    // bit_q is the bit on the wire (0 start, 1..8 data, 9 stop); next_bit follows it
    assign next_bit = (bit_q < 4'd8) ? cur_byte[bit_q[2:0]] : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            msg_q   <= '0;
            rep_q   <= '0;
            midi_tx <= 1'b1;
            led1    <= 1'b0;
            led2    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (evt_valid) begin
                        msg_q          <= {evt_level ? 8'h90 : 8'h80,
                                           8'h3C + {6'd0, evt_idx},
                                           evt_level ? 8'h7F : 8'h00};
                        rep_q[evt_idx] <= evt_level;
                        baud_q         <= '0;
                        bit_q          <= '0;
                        byte_q         <= '0;
                        midi_tx        <= 1'b0;
                        led1           <= 1'b1;
                        state_q        <= StSend;
                    end
                end
                StSend: begin
                    if (baud_q == BW'(BAUD_TOP)) begin
                        baud_q <= '0;
                        if (bit_q == BIT_STOP) begin
                            bit_q <= '0;
                            if (byte_q == BYTE_END) begin
                                midi_tx <= 1'b1;
                                led1    <= 1'b0;
                                led2    <= ~led2;
                                state_q <= StIdle;
                            end else begin
                                byte_q  <= byte_q + 1'b1;
                                midi_tx <= 1'b0;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            midi_tx <= next_bit;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_midi_ctrl.sv
// Directed bench for midi_ctrl: table of button patterns with expected MIDI messages,
// plus hand-written glitch and mid-frame reset sequences.
module tb_midi_ctrl;

    localparam int HALF  = 32;
    localparam int BIT   = 2 * HALF;
    localparam int FRAME = 10 * BIT;
    localparam int MSG   = 3 * FRAME;
    localparam int LAT_LO = 2049;
    localparam int LAT_HI = 2053;

    logic rst, clk, btn1, btn2, btn3, btn4;
    logic led1, led2, midi_tx;

    midi_ctrl #(
        .BAUD_CNT_HALF(HALF),
        .DEBOUNCE_CNT (HALF * 64)
    ) dut (
        .rst    (rst),
        .clk    (clk),
        .btn1   (btn1),
        .btn2   (btn2),
        .btn3   (btn3),
        .btn4   (btn4),
        .led1   (led1),
        .led2   (led2),
        .midi_tx(midi_tx)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct packed {
        logic [3:0]  btns;
        logic [1:0]  n_msg;
        logic [47:0] bytes;
    } vec_t;

    vec_t vecs [6];
    int   n_cmp;
    int   n_bad;
    logic exp_led2;
    int   lat;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic set_btns(input logic [3:0] b);
        {btn4, btn3, btn2, btn1} = b;
    endtask

    // Counts cycles until midi_tx is low; -1 if it stays high past the bound.
    task automatic wait_start(input int bound, output int cycles);
        cycles = 0;
        while (midi_tx !== 1'b0 && cycles <= bound) begin
            tick();
            cycles++;
        end
        if (midi_tx !== 1'b0) cycles = -1;
    endtask

    // Entered on the first cycle of a start bit; leaves one cycle past the last stop bit.
    task automatic recv_msg(input logic [23:0] exp, input string tag);
        logic [23:0] got;
        int led1_bad, frame_bad, f, pos, b;
        got = '0;
        led1_bad = 0;
        frame_bad = 0;
        for (int i = 0; i < MSG; i++) begin
            f   = i / FRAME;
            pos = i % FRAME;
            b   = pos / BIT;
            if (led1 !== 1'b1) led1_bad++;
            if (pos % BIT == BIT / 2) begin
                if (b == 0) begin
                    if (midi_tx !== 1'b0) frame_bad++;
                end else if (b == 9) begin
                    if (midi_tx !== 1'b1) frame_bad++;
                end else begin
                    got[16 - 8 * f + (b - 1)] = midi_tx;
                end
            end
            tick();
        end
        exp_led2 = ~exp_led2;
        chk({tag, " bytes"}, {8'h0, got}, {8'h0, exp});
        chk({tag, " start/stop bits"}, frame_bad, 0);
        chk({tag, " led1 span"}, led1_bad, 0);
        chk({tag, " led1 after"}, {31'h0, led1}, 32'h0);
        chk({tag, " led2 after"}, {31'h0, led2}, {31'h0, exp_led2});
        chk({tag, " tx idle after"}, {31'h0, midi_tx}, 32'h1);
    endtask

    initial begin
        vecs[0] = '{btns: 4'b0001, n_msg: 2'd1, bytes: 48'h903C7F_000000};
        vecs[1] = '{btns: 4'b0000, n_msg: 2'd1, bytes: 48'h803C00_000000};
        vecs[2] = '{btns: 4'b1100, n_msg: 2'd2, bytes: 48'h903E7F_903F7F};
        vecs[3] = '{btns: 4'b0000, n_msg: 2'd2, bytes: 48'h803E00_803F00};
        vecs[4] = '{btns: 4'b0010, n_msg: 2'd1, bytes: 48'h903D7F_000000};
        vecs[5] = '{btns: 4'b0000, n_msg: 2'd1, bytes: 48'h803D00_000000};

        n_cmp = 0;
        n_bad = 0;
        exp_led2 = 1'b0;
        rst = 1'b1;
        set_btns(4'b0000);
        repeat (5) tick();
        rst = 1'b0;

        chk("reset midi_tx", {31'h0, midi_tx}, 32'h1);
        chk("reset led1", {31'h0, led1}, 32'h0);
        chk("reset led2", {31'h0, led2}, 32'h0);
        wait_start(3000, lat);
        chk("idle quiet", lat, -1);

        // Glitches shorter than the debounce window must not produce frames
        set_btns(4'b0010);
        repeat (1000) tick();
        set_btns(4'b0000);
        wait_start(3000, lat);
        chk("btn2 glitch 1000", lat, -1);
        set_btns(4'b1000);
        repeat (2000) tick();
        set_btns(4'b0000);
        wait_start(3000, lat);
        chk("btn4 glitch 2000", lat, -1);
        chk("glitch led1", {31'h0, led1}, 32'h0);

        for (int v = 0; v < 6; v++) begin
            set_btns(vecs[v].btns);
            for (int m = 0; m < int'(vecs[v].n_msg); m++) begin
                if (m == 0) begin
                    wait_start(3000, lat);
                    chk_range($sformatf("vec%0d latency", v), lat, LAT_LO, LAT_HI);
                end else begin
                    wait_start(3, lat);
                    chk($sformatf("vec%0d gap", v), lat, 1);
                end
                if (lat >= 0)
                    recv_msg(vecs[v].bytes[47 - 24 * m -: 24], $sformatf("vec%0d msg%0d", v, m));
            end
        end

        // Reset in the middle of the second byte, button held throughout
        set_btns(4'b0001);
        wait_start(3000, lat);
        chk_range("pre-reset latency", lat, LAT_LO, LAT_HI);
        repeat (FRAME + FRAME / 2) tick();
        chk("pre-reset led1", {31'h0, led1}, 32'h1);
        #3 rst = 1'b1;
        #1;
        chk("mid-frame rst midi_tx", {31'h0, midi_tx}, 32'h1);
        chk("mid-frame rst led1", {31'h0, led1}, 32'h0);
        chk("mid-frame rst led2", {31'h0, led2}, 32'h0);
        exp_led2 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        wait_start(3000, lat);
        chk_range("post-reset latency", lat, LAT_LO, LAT_HI);
        if (lat >= 0) recv_msg(24'h903C7F, "post-reset on");
        set_btns(4'b0000);
        wait_start(3000, lat);
        chk_range("post-reset release latency", lat, LAT_LO, LAT_HI);
        if (lat >= 0) recv_msg(24'h803C00, "post-reset off");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
